// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing generator and pixel output stage for the display path.
// Scans the H_TOTAL x V_TOTAL raster (640x480@60 by default). It drives the
// current coordinate to the drawing objects, takes back the object mux's
// 3:3:2 colour and expands it to 4:4:4. Sync and blank pass through a delay
// line of PIPE_DELAY ticks plus the output register, so they leave the block
// aligned with the colour that the mux returns for the same coordinate.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   RGBIn[7:0]    colour from the object mux, {R[2:0],G[2:0],B[1:0]}
//   pixelX[10:0]  current horizontal count (0..H_TOTAL-1)
//   pixelY[10:0]  current vertical count (0..V_TOTAL-1)
//   pixelValid    current coordinate is inside the active area
//   startOfFrame  high for the whole tick at coordinate (0,0)
//   Red/Green/Blue[3:0]  DAC colour, 0 while blanked
//   hsync/vsync   active-low syncs, aligned to colour
//   blank         high outside the active area, aligned to colour
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1,
  parameter int CLK_DIV    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelValid,
  output logic        startOfFrame,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Pixel tick. With CLK_DIV=2 the tick lands on the second clock of each
  // pair, so after reset the (0,0) coordinate is held for two full clocks.
  logic tick;

  generate
    if (CLK_DIV == 2) begin : g_div2
      logic div_phase;
      always_ff @(posedge clk) begin
        if (reset) div_phase <= 1'b0;
        else       div_phase <= ~div_phase;
      end
      assign tick = div_phase;
    end else begin : g_div1
      assign tick = 1'b1;
    end
  endgenerate

  // Raster counters
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  assign pixelX = h_cnt;
  assign pixelY = v_cnt;

  // Raw decode of the current coordinate
  logic active;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    pixelValid   = active && !reset;
    startOfFrame = (h_cnt == '0) && (v_cnt == '0) && !reset;
  end

  // Sync/blank delay line matching the object mux depth. Each entry is
  // {hs, vs, blank}. The idle entry 3'b111 means syncs inactive and blanked.
  logic [2:0] dly_q [PIPE_DELAY];
  logic [2:0] dly_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b111;
    end else if (tick) begin
      dly_q[0] <= {hs_raw, vs_raw, !active};
      for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dly_out = dly_q[PIPE_DELAY-1];

  // Output register. The MSBs of each colour field are replicated into the
  // low bits so that full-scale 3:3:2 maps to full-scale 4:4:4.
  always_ff @(posedge clk) begin
    if (reset) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
    end else if (tick) begin
      hsync <= dly_out[2];
      vsync <= dly_out[1];
      blank <= dly_out[0];
      if (dly_out[0]) begin
        Red   <= '0;
        Green <= '0;
        Blue  <= '0;
      end else begin
        Red   <= {RGBIn[7:5], RGBIn[7]};
        Green <= {RGBIn[4:2], RGBIn[4]};
        Blue  <= {RGBIn[1:0], RGBIn[1:0]};
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator and pixel output stage for the display path. Scans a 640x480@60 raster and drives the current pixel coordinate to the drawing objects and the priority mux. Takes back the mux's registered 8-bit RGB (3:3:2) and expands it to 4:4:4 for the DAC. Delays hsync/vsync/blank by the known mux pipeline depth so that colour and sync leave the block aligned.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- PIPE_DELAY, 1, ticks from pixelX/pixelY to the matching RGBIn (range 1..4)
- CLK_DIV, 1, clocks per pixel tick (1 or 2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- RGBIn  in  8  colour from the object mux, {R[2:0],G[2:0],B[1:0]}
- pixelX  out  11  current horizontal count (0..H_TOTAL-1)
- pixelY  out  11  current vertical count (0..V_TOTAL-1)
- pixelValid  out  1  pixelX<H_ACTIVE and pixelY<V_ACTIVE
- startOfFrame  out  1  one-tick pulse while pixelX=0, pixelY=0
- Red / Green / Blue  out  4 each  DAC colour, 0 while blanked
- hsync / vsync  out  1 each  active-low syncs, aligned to colour
- blank  out  1  high outside the active area, aligned to colour

## Operation
- H_TOTAL = sum of the H parameters (800). V_TOTAL = sum of the V parameters (525).
- Tick divider: tick=1 every clock when CLK_DIV=1, every 2nd clock when CLK_DIV=2. All counters, the delay line and the output registers advance only on tick. All outputs hold between ticks.
- hCnt increments per tick and wraps H_TOTAL-1 -> 0. On that wrap vCnt increments and wraps V_TOTAL-1 -> 0. pixelX/pixelY are hCnt/vCnt directly (registered).
- Raw sync decode:
  - hsRaw low when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsRaw low when V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blankRaw = !pixelValid.
- Delay line: {hsRaw, vsRaw, blankRaw} shifted PIPE_DELAY ticks. Idle entry is {1,1,1}.
- Output stage, registered on tick:
  - blank, hsync and vsync take the delay-line output.
  - When the delayed blank=1, colour is 0.
  - Otherwise Red={RGBIn[7:5],RGBIn[7]}, Green={RGBIn[4:2],RGBIn[4]}, Blue={RGBIn[1:0],RGBIn[1:0]}.
- pixelValid and startOfFrame are decoded from the counters. Both are forced 0 while reset=1.

## Timing
- Reset (sampled at a clk edge with reset=1):
  - hCnt=vCnt=0 and the divider phase is 0.
  - Delay line is filled with idle entries.
  - Red/Green/Blue=0, hsync=vsync=1, blank=1.
  - pixelValid=startOfFrame=0.
- The first tick after reset deasserts sees pixelX=0, pixelY=0, pixelValid=1, startOfFrame=1.
- Latency: the colour of coordinate (x,y) appears on Red/Green/Blue PIPE_DELAY+1 ticks after pixelX/pixelY showed (x,y). hsync/vsync/blank are aligned to the same tick.
- Line period is 800 ticks with hsync low for 96. Frame period is 420000 ticks with vsync low for 1600 ticks (2 lines).
- vsync edges coincide with the hCnt wrap, delayed by PIPE_DELAY+1.
- Simultaneous hCnt and vCnt wrap at (799,524): the next tick is (0,0) and startOfFrame pulses.
- Reset mid-frame or mid-sync: the block returns to the reset values on the next edge. No partial sync pulse is extended. After reset, the first sync pulse is full length.
- With CLK_DIV=2, each output is stable for exactly 2 clocks. startOfFrame is high for both clocks of its tick.

## Test plan
- Reset values: hold reset 3 clocks, RGBIn=8'hFF -> Red/Green/Blue=0, hsync=vsync=blank=1, pixelValid=0. On the first tick after release, pixelX=0, pixelY=0, startOfFrame=1.
- Line timing (defaults): measure one line -> hsync falls 656+PIPE_DELAY+1 ticks after pixelX=0, stays low 96 ticks, period 800. blank low for exactly 640 ticks per active line.
- Frame timing: run 2 frames -> vsync low for 1600 ticks, period 420000. startOfFrame pulses once per frame. pixelY reaches 524 and wraps to 0.
- Alignment and expansion: bench model registers RGBIn = pixelX[7:0] with PIPE_DELAY=1 -> at the first visible output tick of line 0, Red=0, Green=0, Blue=0. For x=8'hE5 the output is Red=4'hF, Green=4'h2, Blue=4'h5.
- Blanking override: RGBIn forced 8'hFF -> colour=0 whenever blank=1, including pixelX 640..799 and pixelY 480..524.
- Mid-frame reset and divider: assert reset for 1 clock at pixelY=490 (inside vsync) -> next edge vsync=1, counters 0. Repeat with CLK_DIV=2 -> all periods double in clocks and outputs change only on even clocks.
